// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: streaming 2x2 stride-2 signed max-pool with optional ReLU.
// Ports: clk, rstn (async low), in_valid/in_data in, sync_clr, pool_valid/pool_data/pool_last out.
// Build option: define RELU_EN to clamp negative input samples to zero before pooling.
//
// Parameters:
//   DATA_W  sample width, signed two's complement
//   IN_W    input feature-map width (even, >= 4)
//   IN_H    input feature-map height (even, >= 2)
//
// Port summary:
//   clk         clock
//   rstn        asynchronous active-low reset
//   in_valid    input sample strobe, one sample per high cycle
//   in_data     signed input sample
//   sync_clr    synchronous frame restart (drops a coincident sample)
//   pool_valid  one-cycle strobe marking pool_data valid
//   pool_data   signed pooled result, held between strobes
//   pool_last   high with pool_valid on the final pooled sample of a frame

module relu_maxpool_2x2 #(
    parameter int DATA_W = 22,
    parameter int IN_W   = 24,
    parameter int IN_H   = 24
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     sync_clr,
    output logic                     pool_valid,
    output logic signed [DATA_W-1:0] pool_data,
    output logic                     pool_last
);

    localparam int CW = (IN_W > 2) ? $clog2(IN_W) : 2;
    localparam int RW = (IN_H > 2) ? $clog2(IN_H) : 1;
    localparam int HW = CW - 1;
    localparam int LB = IN_W / 2;

    // Raster position of the sample currently on in_data
    logic        [CW-1:0]     r_col;
    logic        [RW-1:0]     r_row;

    // Left sample of the current horizontal pair
    logic signed [DATA_W-1:0] r_pair;

    // Horizontal pair maxima of the even row, one per block column
    logic signed [DATA_W-1:0] r_line_buf [LB];

    logic                     r_pool_valid;
    logic signed [DATA_W-1:0] r_pool_data;
    logic                     r_pool_last;

    logic signed [DATA_W-1:0] w_sample;
    logic signed [DATA_W-1:0] w_pm;
    logic signed [DATA_W-1:0] w_lb_rd;
    logic signed [DATA_W-1:0] w_pool;
    logic        [HW-1:0]     w_idx;
    logic                     w_last_col;
    logic                     w_last_row;
    logic                     w_take;
    logic                     w_lb_wr;

    // Input conditioning
    always_comb begin
`ifdef RELU_EN
        w_sample = in_data[DATA_W-1] ? '0 : in_data;
`else
        w_sample = in_data;
`endif
    end

    assign w_idx      = r_col[CW-1:1];
    assign w_last_col = (r_col == CW'(IN_W - 1));
    assign w_last_row = (r_row == RW'(IN_H - 1));

    // A sample is consumed only when no frame restart is requested
    assign w_take     = in_valid && !sync_clr;

    // Pair max, then max against the stored upper-row pair of the same block
    assign w_pm       = (r_pair > w_sample) ? r_pair : w_sample;
    assign w_lb_rd    = r_line_buf[w_idx];
    assign w_pool     = (w_lb_rd > w_pm) ? w_lb_rd : w_pm;

    // Upper row of a block only writes; lower row only reads the same slot
    assign w_lb_wr    = rstn && w_take && r_col[0] && !r_row[0];

    // Raster counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (sync_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_last_col) begin
                r_col <= '0;
                if (w_last_row) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Pair register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pair <= '0;
        end else if (sync_clr) begin
            r_pair <= '0;
        end else if (in_valid && !r_col[0]) begin
            r_pair <= w_sample;
        end
    end

    // Line buffer has no reset; every slot is written before it is read
    always_ff @(posedge clk) begin
        if (w_lb_wr) begin
            r_line_buf[w_idx] <= w_pm;
        end
    end

    // Output strobe, data and end-of-frame flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pool_valid <= 1'b0;
            r_pool_data  <= '0;
            r_pool_last  <= 1'b0;
        end else if (sync_clr) begin
            r_pool_valid <= 1'b0;
            r_pool_last  <= 1'b0;
        end else begin
            r_pool_valid <= 1'b0;
            r_pool_last  <= 1'b0;
            if (in_valid && r_col[0] && r_row[0]) begin
                r_pool_valid <= 1'b1;
                r_pool_data  <= w_pool;
                r_pool_last  <= w_last_col && w_last_row;
            end
        end
    end

    assign pool_valid = r_pool_valid;
    assign pool_data  = r_pool_data;
    assign pool_last  = r_pool_last;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// tb_relu_maxpool_2x2: randomized scoreboard bench for relu_maxpool_2x2.
// A frame-level reference model queues expected results; a monitor pops them.

module tb_relu_maxpool_2x2;

    localparam int DW = 22;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    logic                 clk;
    logic                 rstn;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 sync_clr;
    logic                 pool_valid;
    logic signed [DW-1:0] pool_data;
    logic                 pool_last;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    int fr [H][W];
    int mrow = 0;
    int mcol = 0;
    int q_data [$];
    bit q_last [$];
    int q_cyc  [$];
    int n_last = 0;

    relu_maxpool_2x2 #(
        .DATA_W(DW),
        .IN_W  (W),
        .IN_H  (H)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .sync_clr  (sync_clr),
        .pool_valid(pool_valid),
        .pool_data (pool_data),
        .pool_last (pool_last)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic model_restart();
        mrow = 0;
        mcol = 0;
    endtask

    // Records the sample into a frame image and, on the bottom-right of a
    // block, queues the max of the four stored samples.
    task automatic model_push(input int v, input int due);
        int s;
        s = v;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        fr[mrow][mcol] = s;
        if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
            q_data.push_back(max4(fr[mrow-1][mcol-1], fr[mrow-1][mcol],
                                  fr[mrow][mcol-1], fr[mrow][mcol]));
            q_last.push_back(mrow == H - 1 && mcol == W - 1);
            q_cyc.push_back(due);
        end
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow++;
            if (mrow == H) mrow = 0;
        end
    endtask

    // Called at posedge+1; sample is captured on the next edge
    task automatic drive(input int v, input int gap);
        in_data  = DW'(v);
        in_valid = 1'b1;
        model_push(v, cyc + 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int rnd_s();
        int v;
        v = int'($urandom_range(0, (1 << DW) - 1));
        if (v > MAXV) v = v - (1 << DW);
        return v;
    endfunction

    task automatic rand_frame(input int gap);
        for (int i = 0; i < W * H; i++) drive(rnd_s(), gap);
    endtask

    task automatic ramp_frame(input int gap);
        for (int i = 0; i < W * H; i++) drive(i, gap);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (pool_valid) begin
            if (q_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pool_data %0d at cycle %0d expected no output",
                         pool_data, cyc);
            end else begin
                int ed;
                bit el;
                int ec;
                ed = q_data.pop_front();
                el = q_last.pop_front();
                ec = q_cyc.pop_front();
                check("pool_data", int'(pool_data), ed);
                check("pool_last", int'(pool_last), int'(el));
                check("latency_cycle", cyc, ec);
                if (pool_last) n_last++;
            end
        end else if (pool_last) begin
            checks++;
            errors++;
            $display("FAIL last_without_valid: got pool_last 1 expected 0 at cycle %0d", cyc);
        end
    end

    initial begin
        int nl;
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sync_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(pool_valid), 0);
        check("reset_data", int'(pool_data), 0);
        check("reset_last", int'(pool_last), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 1: ramp frame, back-to-back
        ramp_frame(0);
        repeat (3) @(posedge clk);
        #1;
        check("frame1_last_count", n_last, 1);

        // 2: ramp frame with 6 idle cycles between samples
        ramp_frame(6);
        repeat (3) @(posedge clk);
        #1;

        // 3: negative block and extremes in one frame
        drive(-3, 0);
        drive(-8, 0);
        drive(MINV, 0);
        drive(MAXV, 0);
        drive(-1, 0);
        drive(-20, 0);
        drive(MINV, 0);
        drive(MINV, 0);
        for (int i = 8; i < W * H; i++) drive(rnd_s(), $urandom_range(0, 2));
        repeat (3) @(posedge clk);
        #1;

        // 4: two frames back-to-back, random data
        nl = n_last;
        rand_frame(0);
        rand_frame(0);
        repeat (3) @(posedge clk);
        #1;
        check("two_frames_last_count", n_last - nl, 2);

        // 5: reset after input index 9, then fresh frame
        for (int i = 0; i < 10; i++) drive(rnd_s(), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        model_restart();
        repeat (2) @(posedge clk);
        #1;
        check("midreset_data", int'(pool_data), 0);
        check("midreset_valid", int'(pool_valid), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        ramp_frame(0);
        repeat (3) @(posedge clk);
        #1;

        // 6: sync_clr mid-row with simultaneous in_valid
        for (int i = 0; i < 7; i++) drive(rnd_s(), 1);
        sync_clr = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(MAXV);
        model_restart();
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        in_valid = 1'b0;
        check("syncclr_valid", int'(pool_valid), 0);
        rand_frame(1);
        rand_frame(0);
        for (int i = 0; i < W * H; i++) drive(rnd_s(), $urandom_range(0, 7));

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", q_data.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
